led_effect_engine: RTL and testbench

- Parametrised successor of the 8-LED fill/drain shift-register effect.
- Drives an N-bit LED bank with four selectable patterns: fill-then-drain, running dot, ping-pong and blink.
- Supports selectable direction, a built-in step prescaler, an enable, and tick/done status pulses for chaining effects.
- Sits between the board clock and the LED pins, replacing the fixed 8-bit shifter.

---
 rtl/led_effect_engine.sv | 118 +++++++++++
 tb/tb_led_effect_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_effect_engine.sv
// N-bit LED pattern engine: fill/drain, running dot, ping-pong and blink,
// with a step prescaler, direction select and tick/done pulses for chaining.
module led_effect_engine #(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [1:0]   mode,
   input  logic         lr,
   output logic [N-1:0] q,
   output logic         tick,
   output logic         done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(2 * N);

   typedef enum logic [1:0] {
      FILL  = 2'b00,
      DOT   = 2'b01,
      PING  = 2'b10,
      BLINK = 2'b11
   } mode_t;

   mode_t         mode_r;
   logic          lr_r;
   logic          load_pending;
   logic [PW-1:0] presc;
   logic [CW-1:0] cnt;
   logic          dir;          // ping-pong: 0 = moving away from the entry end

   logic          load;
   logic [N-1:0]  start_q;
   logic [N-1:0]  next_q;
   logic          next_dir;
   logic          fill_bit;
   logic [CW-1:0] last_step;

   assign load = load_pending || (mode_t'(mode) != mode_r) || (lr != lr_r);

   always_comb begin
      start_q = '0;
      if (mode_t'(mode) == DOT || mode_t'(mode) == PING)
         start_q = lr ? {1'b1, {(N-1){1'b0}}} : N'(1);
   end

   always_comb begin
      case (mode_r)
         FILL:    last_step = CW'(2 * N - 1);
         DOT:     last_step = CW'(N - 1);
         PING:    last_step = CW'(2 * N - 3);
         default: last_step = CW'(1);
      endcase
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      next_q   = q;
      next_dir = dir;
      fill_bit = (cnt < CW'(N));
      case (mode_r)
         FILL:  next_q = lr_r ? {fill_bit, q[N-1:1]} : {q[N-2:0], fill_bit};
         DOT:   next_q = lr_r ? {q[0], q[N-1:1]} : {q[N-2:0], q[N-1]};
         PING: begin
            next_q = (lr_r ^ dir) ? (q >> 1) : (q << 1);
            if (next_q[0] || next_q[N-1])
               next_dir = ~dir;
         end
         default: next_q = {N{cnt == '0}};
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         q            <= '0;
         tick         <= 1'b0;
         done         <= 1'b0;
         presc        <= '0;
         cnt          <= '0;
         dir          <= 1'b0;
         load_pending <= 1'b1;
         mode_r       <= FILL;
         lr_r         <= 1'b0;
      end else if (load) begin
         mode_r       <= mode_t'(mode);
         lr_r         <= lr;
         q            <= start_q;
         presc        <= '0;
         cnt          <= '0;
         dir          <= 1'b0;
         load_pending <= 1'b0;
         tick         <= 1'b0;
         done         <= 1'b0;
      end else if (en) begin
         if (presc == PW'(DIV - 1)) begin
            presc <= '0;
            q     <= next_q;
            dir   <= next_dir;
            tick  <= 1'b1;
            done  <= (cnt == last_step);
            cnt   <= (cnt == last_step) ? '0 : cnt + 1'b1;
         end else begin
            presc <= presc + 1'b1;
            tick  <= 1'b0;
            done  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_led_effect_engine.sv
// Randomised scoreboard bench for led_effect_engine: three instances
// (N=8/DIV=4, N=8/DIV=1, N=2/DIV=3) checked against a closed-form pattern model.
module tb_led_effect_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       lr = 1'b0;

   logic [7:0] q_a, q_b;
   logic [1:0] q_c;
   logic       tick_a, tick_b, tick_c;
   logic       done_a, done_b, done_c;

   always #5 clk = ~clk;

   led_effect_engine #(.N(8), .DIV(4)) dut_a (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .lr(lr),
      .q(q_a), .tick(tick_a), .done(done_a));
   led_effect_engine #(.N(8), .DIV(1)) dut_b (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .lr(lr),
      .q(q_b), .tick(tick_b), .done(done_b));
   led_effect_engine #(.N(2), .DIV(3)) dut_c (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .lr(lr),
      .q(q_c), .tick(tick_c), .done(done_c));

   typedef struct packed {
      logic [2:0][31:0] q;
      logic [2:0]       tick;
      logic [2:0]       done;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   int   nv[3] = '{8, 8, 2};
   int   dv[3] = '{4, 1, 3};

   bit          m_pend[3];
   logic [1:0]  m_mode[3];
   bit          m_lr[3];
   int          m_clks[3];
   int          m_steps[3];
   logic [31:0] m_q[3];
   bit          m_tick[3];
   bit          m_done[3];

   function automatic int period(int n, logic [1:0] m);
      case (m)
         2'b00:   return 2 * n;
         2'b01:   return n;
         2'b10:   return 2 * n - 2;
         default: return 2;
      endcase
   endfunction

   // LED image k steps after a load, derived directly from the pattern rules.
   function automatic logic [31:0] pattern(int n, logic [1:0] m, bit l, int k);
      logic [63:0] r;
      int j, d, pos, p;
      r = 64'd0;
      p = period(n, m);
      j = k % p;
      case (m)
         2'b00: begin
            if (j <= n)
               r = l ? (((64'd1 << j) - 64'd1) << (n - j)) : ((64'd1 << j) - 64'd1);
            else begin
               d = j - n;
               r = l ? ((64'd1 << (n - d)) - 64'd1) : (((64'd1 << (n - d)) - 64'd1) << d);
            end
         end
         2'b01: begin
            pos = l ? (n - 1 - j) : j;
            r = 64'd1 << pos;
         end
         2'b10: begin
            d = (j <= n - 1) ? j : (p - j);
            pos = l ? (n - 1 - d) : d;
            r = 64'd1 << pos;
         end
         default: r = (j == 1) ? ((64'd1 << n) - 64'd1) : 64'd0;
      endcase
      return r[31:0];
   endfunction

   task automatic model_edge(input int i, input bit r, input bit e,
                             input logic [1:0] m, input bit l);
      m_tick[i] = 1'b0;
      m_done[i] = 1'b0;
      if (r) begin
         m_pend[i]  = 1'b1;
         m_q[i]     = 32'd0;
         m_clks[i]  = 0;
         m_steps[i] = 0;
      end else if (m_pend[i] || m != m_mode[i] || l != m_lr[i]) begin
         m_pend[i]  = 1'b0;
         m_mode[i]  = m;
         m_lr[i]    = l;
         m_clks[i]  = 0;
         m_steps[i] = 0;
         m_q[i]     = pattern(nv[i], m, l, 0);
      end else if (e) begin
         m_clks[i]++;
         if (m_clks[i] % dv[i] == 0) begin
            m_steps[i]++;
            m_q[i]    = pattern(nv[i], m, l, m_steps[i]);
            m_tick[i] = 1'b1;
            m_done[i] = (m_steps[i] % period(nv[i], m) == 0);
         end
      end
   endtask

   task automatic drive(input bit r, input bit e, input logic [1:0] m, input bit l);
      exp_t x;
      @(negedge clk);
      reset = r;
      en    = e;
      mode  = m;
      lr    = l;
      for (int i = 0; i < 3; i++) begin
         model_edge(i, r, e, m, l);
         x.q[i]    = m_q[i];
         x.tick[i] = m_tick[i];
         x.done[i] = m_done[i];
      end
      sb.push_back(x);
   endtask

   task automatic run(input int cycles, input bit r, input bit e,
                      input logic [1:0] m, input bit l);
      for (int c = 0; c < cycles; c++)
         drive(r, e, m, l);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      exp_t        x;
      logic [31:0] aq[3];
      logic [2:0]  at, ad;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            aq[0] = {24'd0, q_a};
            aq[1] = {24'd0, q_b};
            aq[2] = {30'd0, q_c};
            at = {tick_c, tick_b, tick_a};
            ad = {done_c, done_b, done_a};
            for (int i = 0; i < 3; i++) begin
               check($sformatf("q[%0d]", i), aq[i], x.q[i]);
               check($sformatf("tick[%0d]", i), 32'(at[i]), 32'(x.tick[i]));
               check($sformatf("done[%0d]", i), 32'(ad[i]), 32'(x.done[i]));
            end
         end
      end
   end

   initial begin
      logic [1:0] cm;
      bit         cl;
      for (int i = 0; i < 3; i++) begin
         m_pend[i] = 1'b1;  m_mode[i] = 2'b00; m_lr[i] = 1'b0;
         m_clks[i] = 0;     m_steps[i] = 0;    m_q[i] = 32'd0;
         m_tick[i] = 1'b0;  m_done[i] = 1'b0;
      end

      run(3, 1, 1, 2'b00, 1);
      run(70, 0, 1, 2'b00, 1);   // fill/drain from MSB
      run(70, 0, 1, 2'b00, 0);   // fill/drain from LSB
      run(40, 0, 1, 2'b01, 0);   // running dot
      run(64, 0, 1, 2'b10, 1);   // ping-pong
      run(20, 0, 1, 2'b11, 1);   // blink
      run(13, 0, 1, 2'b00, 1);   // reach E0, then flip direction
      run(10, 0, 1, 2'b00, 0);
      run(6, 0, 1, 2'b01, 0);    // mode change mid-step
      run(17, 0, 1, 2'b00, 1);   // reach F0, then hold
      run(10, 0, 0, 2'b00, 1);
      run(10, 0, 1, 2'b00, 1);
      run(1, 1, 1, 2'b00, 1);    // reset mid-pattern
      run(10, 0, 1, 2'b00, 1);

      cm = 2'b10;
      cl = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            cm = 2'($urandom_range(0, 3));
            cl = 1'($urandom_range(0, 1));
         end
         drive($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, cm, cl);
      end

      for (int w = 0; w < 5 && sb.size() > 0; w++)
         @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
